// File: rtl/rc4_pkg.sv
// Constants and state encoding shared by the RC4 PRGA decrypt stage and the key-search controller.
package rc4_pkg;

  localparam logic [7:0] CHAR_SPACE = 8'd32;
  localparam logic [7:0] CHAR_LO    = 8'd97;
  localparam logic [7:0] CHAR_HI    = 8'd122;

  localparam int MSG_LEN_DEFAULT = 32;
  localparam int MSG_AW_DEFAULT  = 5;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_P_I   = 4'd1,
    ST_P_WI  = 4'd2,
    ST_P_RI  = 4'd3,
    ST_P_WJ  = 4'd4,
    ST_P_RJ  = 4'd5,
    ST_P_WRI = 4'd6,
    ST_P_F   = 4'd7,
    ST_P_WF  = 4'd8,
    ST_P_X   = 4'd9,
    ST_P_NX  = 4'd10,
    ST_DONE  = 4'd11
  } prga_state_t;

endpackage

// File: rtl/rc4_char_valid.sv
// Plaintext legality test: space or lowercase 'a'..'z'.
module rc4_char_valid
  import rc4_pkg::*;
(
  input  logic [7:0] ch,
  output logic       legal
);

  assign legal = (ch == CHAR_SPACE) || ((ch >= CHAR_LO) && (ch <= CHAR_HI));

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 pseudo-random generation over a scheduled S-box; decrypts the ciphertext ROM into the
// plaintext RAM and reports whether every byte was a legal character.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT,
  parameter int MSG_AW  = MSG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        s_q,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_data,
  output logic              s_wren,
  output logic [MSG_AW-1:0] enc_addr,
  input  logic [7:0]        enc_q,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_data,
  output logic              dec_wren,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MSG_AW-1:0] fail_index
);

  localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

  prga_state_t       state;
  logic [7:0]        i;
  logic [7:0]        j;
  logic [7:0]        si;
  logic [7:0]        sj;
  logic [MSG_AW-1:0] k;
  logic [7:0]        plain;
  logic              plain_legal;
  logic              byte_legal;

  assign plain = s_q ^ enc_q;

  rc4_char_valid u_char_valid (
    .ch    (plain),
    .legal (plain_legal)
  );

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

  // Memory reads return data two states after the address is issued, hence the wait states.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      i          <= 8'd0;
      j          <= 8'd0;
      k          <= '0;
      si         <= 8'd0;
      sj         <= 8'd0;
      s_addr     <= 8'd0;
      s_data     <= 8'd0;
      s_wren     <= 1'b0;
      enc_addr   <= '0;
      dec_addr   <= '0;
      dec_data   <= 8'd0;
      dec_wren   <= 1'b0;
      pass       <= 1'b0;
      fail_index <= '0;
      byte_legal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            i          <= 8'd0;
            j          <= 8'd0;
            k          <= '0;
            pass       <= 1'b0;
            fail_index <= '0;
            state      <= ST_P_I;
          end
        end
        ST_P_I: begin
          i        <= i + 8'd1;
          s_addr   <= i + 8'd1;
          enc_addr <= k;
          state    <= ST_P_WI;
        end
        ST_P_WI: state <= ST_P_RI;
        ST_P_RI: begin
          si     <= s_q;
          j      <= j + s_q;
          s_addr <= j + s_q;
          state  <= ST_P_WJ;
        end
        ST_P_WJ: state <= ST_P_RJ;
        // Swap S[i] and S[j] as two back-to-back writes; i==j simply writes the same value twice.
        ST_P_RJ: begin
          sj     <= s_q;
          s_addr <= j;
          s_data <= si;
          s_wren <= 1'b1;
          state  <= ST_P_WRI;
        end
        ST_P_WRI: begin
          s_addr <= i;
          s_data <= sj;
          s_wren <= 1'b1;
          state  <= ST_P_F;
        end
        ST_P_F: begin
          s_wren <= 1'b0;
          s_addr <= si + sj;
          state  <= ST_P_WF;
        end
        ST_P_WF: state <= ST_P_X;
        ST_P_X: begin
          dec_addr   <= k;
          dec_data   <= plain;
          dec_wren   <= 1'b1;
          byte_legal <= plain_legal;
          state      <= ST_P_NX;
        end
        // The byte is always written before the verdict, so an illegal byte lands in RAM too.
        ST_P_NX: begin
          dec_wren <= 1'b0;
          if (!byte_legal) begin
            fail_index <= k;
            pass       <= 1'b0;
            state      <= ST_DONE;
          end else if (k == LAST_K) begin
            pass  <= 1'b1;
            state <= ST_DONE;
          end else begin
            k     <= k + 1'b1;
            state <= ST_P_I;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt: table vectors, reset/start corner sequences and
// randomized runs compared against a plain RC4 reference model.
module tb_rc4_prga_decrypt;

  localparam int MSG_LEN = 32;
  localparam int MSG_AW  = 5;
  localparam int MAX_CYCLES = 400;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [7:0]        s_q;
  logic [7:0]        s_addr;
  logic [7:0]        s_data;
  logic              s_wren;
  logic [MSG_AW-1:0] enc_addr;
  logic [7:0]        enc_q;
  logic [MSG_AW-1:0] dec_addr;
  logic [7:0]        dec_data;
  logic              dec_wren;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MSG_AW-1:0] fail_index;

  rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .s_q        (s_q),
    .s_addr     (s_addr),
    .s_data     (s_data),
    .s_wren     (s_wren),
    .enc_addr   (enc_addr),
    .enc_q      (enc_q),
    .dec_addr   (dec_addr),
    .dec_data   (dec_data),
    .dec_wren   (dec_wren),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_index (fail_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  s_mem   [256];
  logic [7:0]  s_init  [256];
  logic [7:0]  exp_s   [256];
  logic [7:0]  enc_rom [MSG_LEN];
  logic [7:0]  pt      [MSG_LEN];
  logic        load_s;
  logic [15:0] dec_log [$];
  logic [15:0] s_log   [$];

  int checks;
  int errors;
  int exp_n;
  bit exp_pass;
  int exp_fail;

  // Environment memories: S-box RAM and ciphertext ROM, both with one-cycle synchronous reads.
  always @(posedge clk) begin
    if (load_s) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
    end else if (s_wren) begin
      s_mem[s_addr] <= s_data;
    end
    s_q   <= s_mem[s_addr];
    enc_q <= enc_rom[enc_addr];
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (dec_wren) dec_log.push_back({{(8 - MSG_AW){1'b0}}, dec_addr, dec_data});
      if (s_wren)   s_log.push_back({s_addr, s_data});
    end
  end

  typedef struct {
    bit         ident;
    int         fidx;
    logic [7:0] fval;
    bit         e_pass;
    int         e_fail;
    int         e_cycles;
    bit         chk_dec0;
    logic [7:0] e_dec0;
  } vec_t;

  vec_t vecs [7];

  function automatic bit legal_char(input logic [7:0] c);
    return (c == 8'd32) || ((c >= 8'd97) && (c <= 8'd122));
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: standard RC4 PRGA on a copy of the S-box; plaintext is chosen first, ciphertext derived.
  task automatic build_case(input bit ident, input int fidx, input logic [7:0] fval);
    logic [7:0] work [256];
    logic [7:0] ii, jj, tmp, t, ks;
    int r;
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    if (!ident) begin
      for (int a = 255; a > 0; a--) begin
        r = $urandom_range(0, a);
        tmp = s_init[a]; s_init[a] = s_init[r]; s_init[r] = tmp;
      end
    end
    exp_n = MSG_LEN; exp_pass = 1'b1; exp_fail = 0;
    for (int m = 0; m < MSG_LEN; m++) begin
      r = $urandom_range(0, 26);
      pt[m] = (r == 26) ? 8'd32 : 8'(97 + r);
      if (m == fidx) pt[m] = fval;
      if (exp_pass && !legal_char(pt[m])) begin
        exp_pass = 1'b0; exp_fail = m; exp_n = m + 1;
      end
    end
    for (int a = 0; a < 256; a++) work[a] = s_init[a];
    ii = 8'd0; jj = 8'd0;
    for (int m = 0; m < MSG_LEN; m++) begin
      ii = ii + 8'd1;
      jj = jj + work[ii];
      tmp = work[ii]; work[ii] = work[jj]; work[jj] = tmp;
      t = work[ii] + work[jj];
      ks = work[t];
      enc_rom[m] = pt[m] ^ ks;
      if (m == exp_n - 1) for (int a = 0; a < 256; a++) exp_s[a] = work[a];
    end
  endtask

  task automatic load_sbox();
    @(negedge clk); load_s = 1'b1;
    @(negedge clk); load_s = 1'b0;
  endtask

  task automatic apply_stimulus(input bit pulse_busy, output int cycles);
    dec_log.delete();
    s_log.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 1;
    check_val("done_cleared_after_start", done, 0);
    check_val("busy_after_start", busy, 1);
    while (!done && cycles < MAX_CYCLES) begin
      start = (pulse_busy && (cycles % 37 == 5)) ? 1'b1 : 1'b0;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    if (!done) check_val("done_timeout", done, 1);
  endtask

  task automatic check_output(input string tag, input int cycles, input bit e_pass,
                              input int e_fail, input int e_cycles);
    logic [15:0] ent;
    int bad;
    check_val({tag, " cycles"}, cycles, e_cycles);
    check_val({tag, " pass"}, pass, e_pass);
    if (!e_pass) check_val({tag, " fail_index"}, fail_index, e_fail);
    check_val({tag, " busy"}, busy, 0);
    check_val({tag, " dec_writes"}, dec_log.size(), exp_n);
    for (int m = 0; m < exp_n && m < dec_log.size(); m++) begin
      ent = dec_log[m];
      check_val({tag, " dec_addr"}, ent[15:8], m);
      check_val({tag, " dec_data"}, ent[7:0], pt[m]);
    end
    check_val({tag, " s_writes"}, s_log.size(), 2 * exp_n);
    bad = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] != exp_s[a]) bad++;
    check_val({tag, " sbox_mismatches"}, bad, 0);
    repeat (3) @(negedge clk);
    check_val({tag, " done_held"}, done, 1);
    check_val({tag, " no_extra_dec"}, dec_log.size(), exp_n);
  endtask

  initial begin
    int cycles;
    int fidx;
    logic [7:0] fval;
    logic [15:0] ent;
    checks = 0; errors = 0;
    reset_n = 1'b0; start = 1'b0; load_s = 1'b0;
    for (int m = 0; m < MSG_LEN; m++) enc_rom[m] = 8'd0;
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);

    vecs[0] = '{1'b1, 0,  8'h61,  1'b1, 0,  321, 1'b1, 8'h61};
    vecs[1] = '{1'b1, 0,  8'h02,  1'b0, 0,  11,  1'b1, 8'h02};
    vecs[2] = '{1'b1, 8,  8'h5C,  1'b0, 8,  91,  1'b0, 8'h00};
    vecs[3] = '{1'b1, 31, 8'h7B,  1'b0, 31, 321, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 31, 8'd122, 1'b1, 0,  321, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 5,  8'd96,  1'b0, 5,  61,  1'b0, 8'h00};
    vecs[6] = '{1'b0, 3,  8'd32,  1'b1, 0,  321, 1'b0, 8'h00};

    repeat (3) @(negedge clk);
    check_val("rst s_addr", s_addr, 0);
    check_val("rst s_data", s_data, 0);
    check_val("rst s_wren", s_wren, 0);
    check_val("rst enc_addr", enc_addr, 0);
    check_val("rst dec_addr", dec_addr, 0);
    check_val("rst dec_data", dec_data, 0);
    check_val("rst dec_wren", dec_wren, 0);
    check_val("rst busy", busy, 0);
    check_val("rst done", done, 0);
    check_val("rst pass", pass, 0);
    check_val("rst fail_index", fail_index, 0);
    reset_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      build_case(vecs[t].ident, vecs[t].fidx, vecs[t].fval);
      load_sbox();
      apply_stimulus(1'b0, cycles);
      check_output($sformatf("vec%0d", t), cycles, vecs[t].e_pass, vecs[t].e_fail, vecs[t].e_cycles);
      if (vecs[t].chk_dec0) begin
        if (dec_log.size() > 0) begin
          ent = dec_log[0];
          check_val($sformatf("vec%0d dec0", t), ent[7:0], vecs[t].e_dec0);
        end else begin
          check_val($sformatf("vec%0d dec0_present", t), 0, 1);
        end
      end
      // Identity S-box: byte0 swaps S[1] with itself, byte1 swaps S[2]/S[3].
      if (t == 0) begin
        if (s_log.size() >= 4) begin
          check_val("ident s_write0", s_log[0], 16'h0101);
          check_val("ident s_write1", s_log[1], 16'h0101);
          check_val("ident s_write2", s_log[2], 16'h0302);
          check_val("ident s_write3", s_log[3], 16'h0203);
        end else begin
          check_val("ident s_write_count", s_log.size(), 4);
        end
      end
    end

    // Reset asserted while sitting in the first-write state of byte 0.
    build_case(1'b1, -1, 8'h00);
    load_sbox();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("midrst busy_before", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("midrst s_wren", s_wren, 0);
    check_val("midrst busy", busy, 0);
    check_val("midrst done", done, 0);
    check_val("midrst s_addr", s_addr, 0);
    reset_n = 1'b1;
    load_sbox();
    apply_stimulus(1'b0, cycles);
    check_output("after_midrst", cycles, exp_pass, exp_fail, 10 * exp_n + 1);

    for (int r = 0; r < 6; r++) begin
      fidx = -1;
      fval = 8'h00;
      if (r % 2 == 1) begin
        fidx = $urandom_range(0, MSG_LEN - 1);
        do fval = 8'($urandom_range(0, 255)); while (legal_char(fval));
      end
      build_case(1'b0, fidx, fval);
      load_sbox();
      apply_stimulus(r >= 3, cycles);
      check_output($sformatf("rand%0d", r), cycles, exp_pass, exp_fail, 10 * exp_n + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
